// File: rtl/rf_pkg.sv
// Shared sizing defaults and the address-width helper for the register file.
package rf_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;

   // Ceiling log2, with a floor of 1 so a 2-entry file still has a 1-bit address
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

   localparam int unsigned ADDR_W_DEF = clog2(NREGS_DEF);

endpackage

// File: rtl/rf_wr_sel.sv
// Fixed-priority match of one address against all write ports; highest-index port wins.
module rf_wr_sel
   import rf_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NWRITE = 1
) (
   input  logic [ADDR_W-1:0]        addr,
   input  logic [NWRITE-1:0]        wen,
   input  logic [NWRITE*ADDR_W-1:0] waddr,
   input  logic [NWRITE*XLEN-1:0]   wdata,
   output logic                     hit_c,
   output logic [XLEN-1:0]          data_c
);

   // Ascending scan: later (higher) ports overwrite earlier matches
   always_comb begin
      hit_c  = 1'b0;
      data_c = '0;
      for (int k = 0; k < int'(NWRITE); k++) begin
         if (wen[k] && (waddr[k*ADDR_W +: ADDR_W] == addr)) begin
            hit_c  = 1'b1;
            data_c = wdata[k*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/rf_sb.sv
// Multi-port integer register file with a per-register busy scoreboard and optional
// same-cycle write-to-read bypass. Register 0 is hardwired to zero and never busy.
module rf_sb
   import rf_pkg::*;
#(
   parameter int unsigned  XLEN      = XLEN_DEF,
   parameter int unsigned  NREGS     = NREGS_DEF,
   parameter int unsigned  NREAD     = 2,
   parameter int unsigned  NWRITE    = 1,
   parameter int unsigned  BYPASS_EN = 0,
   localparam int unsigned ADDR_W    = clog2(NREGS)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NREAD*ADDR_W-1:0]  i_rs_raddr,
   output logic [NREAD*XLEN-1:0]    o_rs_rdata,
   output logic [NREAD-1:0]         o_rs_busy,
   input  logic [NWRITE-1:0]        i_rd_wen,
   input  logic [NWRITE*ADDR_W-1:0] i_rd_waddr,
   input  logic [NWRITE*XLEN-1:0]   i_rd_wdata,
   input  logic                     i_alloc_en,
   input  logic [ADDR_W-1:0]        i_alloc_addr,
   output logic [ADDR_W:0]          o_busy_count
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;

   logic [NREGS-1:1] wr_hit;
   logic [XLEN-1:0]  wr_data [1:NREGS-1];

   logic [NREAD-1:0] byp_hit;
   logic [XLEN-1:0]  byp_data [NREAD];

   // One write selector per architectural register (x0 has none, so it is never written)
   for (genvar r = 1; r < int'(NREGS); r++) begin : g_wsel
      rf_wr_sel #(
         .XLEN   (XLEN),
         .ADDR_W (ADDR_W),
         .NWRITE (NWRITE)
      ) u_sel (
         .addr   (ADDR_W'(r)),
         .wen    (i_rd_wen),
         .waddr  (i_rd_waddr),
         .wdata  (i_rd_wdata),
         .hit_c  (wr_hit[r]),
         .data_c (wr_data[r])
      );
   end

   // One selector per read port for forwarding the winning write
   for (genvar p = 0; p < int'(NREAD); p++) begin : g_bsel
      rf_wr_sel #(
         .XLEN   (XLEN),
         .ADDR_W (ADDR_W),
         .NWRITE (NWRITE)
      ) u_sel (
         .addr   (i_rs_raddr[p*ADDR_W +: ADDR_W]),
         .wen    (i_rd_wen),
         .waddr  (i_rd_waddr),
         .wdata  (i_rd_wdata),
         .hit_c  (byp_hit[p]),
         .data_c (byp_data[p])
      );
   end

   // Array and scoreboard; a same-cycle alloc beats the write's busy-clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int r = 0; r < int'(NREGS); r++) regs[r] <= '0;
         busy <= '0;
      end else begin
         for (int r = 1; r < int'(NREGS); r++) begin
            if (wr_hit[r]) regs[r] <= wr_data[r];
            if (i_alloc_en && (i_alloc_addr == ADDR_W'(r))) busy[r] <= 1'b1;
            else if (wr_hit[r])                             busy[r] <= 1'b0;
         end
      end
   end

   // Combinational read ports; forwarding is held off during reset
   always_comb begin
      o_rs_rdata = '0;
      o_rs_busy  = '0;
      for (int p = 0; p < int'(NREAD); p++) begin
         o_rs_rdata[p*XLEN +: XLEN] = regs[i_rs_raddr[p*ADDR_W +: ADDR_W]];
         o_rs_busy[p]               = busy[i_rs_raddr[p*ADDR_W +: ADDR_W]];
         if (i_rs_raddr[p*ADDR_W +: ADDR_W] == '0) begin
            o_rs_rdata[p*XLEN +: XLEN] = '0;
            o_rs_busy[p]               = 1'b0;
         end else if ((BYPASS_EN != 0) && !i_rst && byp_hit[p]) begin
            o_rs_rdata[p*XLEN +: XLEN] = byp_data[p];
            o_rs_busy[p]               = 1'b0;
         end
      end
   end

   // Popcount of pending writers
   always_comb begin
      o_busy_count = '0;
      for (int r = 1; r < int'(NREGS); r++) begin
         o_busy_count = o_busy_count + (ADDR_W+1)'(busy[r]);
      end
   end

endmodule

// File: tb/tb_rf_sb.sv
// Scoreboard bench: bypass and non-bypass rf_sb instances share stimulus; a monitor
// compares each cycle's outputs against queued hand-computed expectations.
module tb_rf_sb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [2*AW-1:0]   raddr;
   logic [1:0]        wen;
   logic [2*AW-1:0]   waddr;
   logic [2*XLEN-1:0] wdata;
   logic              alloc_en;
   logic [AW-1:0]     alloc_addr;

   logic [2*XLEN-1:0] rdata_b, rdata_n;
   logic [1:0]        busy_b, busy_n;
   logic [AW:0]       cnt_b, cnt_n;

   always #5 clk = ~clk;

   rf_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS_EN(1)) u_byp (
      .i_clk(clk), .i_rst(rst), .i_rs_raddr(raddr), .o_rs_rdata(rdata_b), .o_rs_busy(busy_b),
      .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata),
      .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_busy_count(cnt_b));

   rf_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS_EN(0)) u_nob (
      .i_clk(clk), .i_rst(rst), .i_rs_raddr(raddr), .o_rs_rdata(rdata_n), .o_rs_busy(busy_n),
      .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata),
      .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_busy_count(cnt_n));

   typedef struct {
      string       name;
      int          cyc;
      bit          inst;   // 0 = bypass instance, 1 = non-bypass instance
      int          port;
      logic [31:0] data;
      logic        busy;
      logic [5:0]  cnt;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pop every expectation tagged with the current cycle and compare
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] ad;
      logic        ab;
      logic [5:0]  ac;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e  = sbq.pop_front();
         ad = e.inst ? rdata_n[e.port*32 +: 32] : rdata_b[e.port*32 +: 32];
         ab = e.inst ? busy_n[e.port] : busy_b[e.port];
         ac = e.inst ? cnt_n : cnt_b;
         vectors++;
         if (e.cyc != cyc || ad !== e.data || ab !== e.busy || ac !== e.cnt) begin
            miscompares++;
            $display("FAIL %s inst%0d port%0d cyc%0d/%0d: got data=%h busy=%b cnt=%0d, want data=%h busy=%b cnt=%0d",
                     e.name, e.inst, e.port, cyc, e.cyc, ad, ab, ac, e.data, e.busy, e.cnt);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      wen      = '0;
      alloc_en = 1'b0;
   endtask

   task automatic rd(input int p, input int a);
      raddr[p*AW +: AW] = AW'(a);
   endtask

   task automatic wr(input int p, input int a, input logic [31:0] d);
      wen[p]             = 1'b1;
      waddr[p*AW +: AW]  = AW'(a);
      wdata[p*32 +: 32]  = d;
   endtask

   task automatic alloc(input int a);
      alloc_en   = 1'b1;
      alloc_addr = AW'(a);
   endtask

   task automatic expect1(input string nm, input bit inst, input int p,
                          input logic [31:0] d, input logic b, input int c);
      exp_t e;
      e.name = nm; e.cyc = cyc; e.inst = inst; e.port = p;
      e.data = d; e.busy = b; e.cnt = 6'(c);
      sbq.push_back(e);
   endtask

   task automatic expect2(input string nm, input int p, input logic [31:0] d, input logic b, input int c);
      expect1(nm, 1'b0, p, d, b, c);
      expect1(nm, 1'b1, p, d, b, c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; raddr = '0; wen = '0; waddr = '0; wdata = '0;
      alloc_en = 1'b0; alloc_addr = '0;
      tick();
      rst = 1'b0;

      // Reset state: every address on both ports reads zero, not busy
      for (int a = 0; a < 32; a++) begin
         rd(0, a); rd(1, 31 - a);
         expect2("reset_rd_p0", 0, 32'h0, 1'b0, 0);
         expect2("reset_rd_p1", 1, 32'h0, 1'b0, 0);
         tick();
      end

      // Write collision on x5: port 1 wins, and wins the bypass too
      rd(0, 5);
      wr(0, 5, 32'h11111111); wr(1, 5, 32'h22222222);
      expect1("collide_byp", 1'b0, 0, 32'h22222222, 1'b0, 0);
      expect1("collide_nob", 1'b1, 0, 32'h00000000, 1'b0, 0);
      tick();
      expect2("collide_after", 0, 32'h22222222, 1'b0, 0);
      tick();

      // Alloc x7 is not forwarded; busy next cycle; write clears it
      rd(0, 7); alloc(7);
      expect2("alloc7_same", 0, 32'h0, 1'b0, 0);
      tick();
      expect2("alloc7_after", 0, 32'h0, 1'b1, 1);
      tick();
      wr(0, 7, 32'hCAFEBABE);
      expect1("wr7_byp", 1'b0, 0, 32'hCAFEBABE, 1'b0, 1);
      expect1("wr7_nob", 1'b1, 0, 32'h00000000, 1'b1, 1);
      tick();
      expect2("wr7_after", 0, 32'hCAFEBABE, 1'b0, 0);
      tick();

      // Busy x10 written via port 1 while read on port 1
      alloc(10);
      tick();
      rd(1, 10); wr(1, 10, 32'hDEADBEEF);
      expect1("wr10_byp", 1'b0, 1, 32'hDEADBEEF, 1'b0, 1);
      expect1("wr10_nob", 1'b1, 1, 32'h00000000, 1'b1, 1);
      tick();
      expect2("wr10_after", 1, 32'hDEADBEEF, 1'b0, 0);
      tick();

      // Same-cycle alloc and write to x3: data lands, busy ends set
      rd(1, 3); alloc(3); wr(0, 3, 32'h55555555);
      expect1("aw3_byp", 1'b0, 1, 32'h55555555, 1'b0, 0);
      expect1("aw3_nob", 1'b1, 1, 32'h00000000, 1'b0, 0);
      tick();
      expect2("aw3_after", 1, 32'h55555555, 1'b1, 1);
      tick();

      // x0 ignores writes and allocs and is never bypassed
      rd(0, 0); wr(0, 0, 32'hFFFFFFFF); alloc(0);
      expect2("x0_same", 0, 32'h0, 1'b0, 1);
      tick();
      expect2("x0_after", 0, 32'h0, 1'b0, 1);
      tick();

      // Allocate x1..x31 (x3 is already busy and stays busy)
      for (int a = 1; a < 32; a++) begin
         alloc(a);
         tick();
      end

      // Reset cycle with a write and an alloc that must be discarded; bypass held off
      rst = 1'b1; rd(0, 5); wr(1, 5, 32'hAAAAAAAA); alloc(2);
      expect2("pre_reset", 0, 32'h22222222, 1'b1, 31);
      tick();
      rst = 1'b0;
      expect2("post_reset_x5", 0, 32'h0, 1'b0, 0);
      tick();
      for (int a = 1; a < 32; a++) begin
         rd(0, a); rd(1, a);
         expect1("post_reset_p0", 1'b0, 0, 32'h0, 1'b0, 0);
         expect1("post_reset_p1", 1'b1, 1, 32'h0, 1'b0, 0);
         tick();
      end

      // Normal operation resumes after reset
      wr(0, 7, 32'h12345678); alloc(9);
      tick();
      rd(0, 7); rd(1, 9);
      expect2("resume_x7", 0, 32'h12345678, 1'b0, 1);
      expect2("resume_x9", 1, 32'h00000000, 1'b1, 1);
      tick();

      @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rf_sb.md
# rf_sb

Parametrised multi-port integer register file with an integrated per-register busy scoreboard, the next generation of the single-write, dual-read `rf` used by the core's decode stage. It supports NREAD read ports, NWRITE write ports with fixed priority, optional same-cycle write-to-read bypass, and hazard tracking: issue allocates a destination and marks it busy; writeback stores data and clears the busy bit. It sits between decode/issue (read, allocate) and writeback (write).

## Interface
Parameters:
- XLEN, 32, data width per register
- NREGS, 32, register count (power of two, ≥2); ADDR_W = clog2(NREGS)
- NREAD, 2, read port count (≥1)
- NWRITE, 1, write port count (≥1)
- BYPASS_EN, 0, 1 = forward same-cycle write data and busy-clear to read ports

Ports (port k occupies bits [k*W +: W] of each flat vector):
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_rs_raddr  in  NREAD*ADDR_W  read addresses
- o_rs_rdata  out  NREAD*XLEN  read data
- o_rs_busy  out  NREAD  addressed register has a pending writer
- i_rd_wen  in  NWRITE  write enables
- i_rd_waddr  in  NWRITE*ADDR_W  write addresses
- i_rd_wdata  in  NWRITE*XLEN  write data
- i_alloc_en  in  1  mark i_alloc_addr busy
- i_alloc_addr  in  ADDR_W  destination being issued
- o_busy_count  out  ADDR_W+1  number of busy registers

## Operation
- Register 0 hardwired: reads 0, never busy; writes and allocs to 0 ignored (never bypassed).
- Reads combinational from array and busy flops.
- Write collision (several enabled ports, same address): highest-index port wins; data and clear both from that port.
- Write with address ≠ 0: register ← wdata, busy ← 0 at the edge.
- Alloc with address ≠ 0: busy ← 1 at the edge. Alloc and write to the same register in one cycle: data written, busy ends 1 (new producer wins).
- Alloc of an already-busy register: stays busy, no error.
- BYPASS_EN=1: if read address ≠ 0 matches an enabled write port, rdata = winning port's wdata and busy = 0; alloc is never forwarded (visible next cycle). BYPASS_EN=0: reads reflect flops only.
- o_busy_count = popcount of busy flops (excludes register 0); range 0..NREGS-1.

## Timing
- Read latency 0 cycles (combinational); write/alloc visible to flop-based reads 1 cycle after the edge.
- Reset (i_rst high at an edge): all registers 0, all busy 0, o_busy_count 0; writes and allocs in that cycle discarded. While i_rst is high, bypass is suppressed.
- Reset asserted mid-sequence with allocs pending: all busy cleared; subsequent writes to those registers behave normally.
- No back-pressure; every enabled write/alloc is accepted in its cycle.

## Structure
- Package/header rf_pkg: default XLEN, NREGS, clog2 function, ADDR_W derivation.
- Sub-module rf_wr_sel: per-address priority select over NWRITE ports → (hit, wdata); instantiated once per register for write and once per read port for bypass.
- Array and busy vector live in rf_sb; popcount is a loop in rf_sb.

## Test plan
- Reset, then read all ports at every address → rdata 0, busy 0, o_busy_count 0.
- NWRITE=2: both ports write x5 (port0 0x11111111, port1 0x22222222) → next cycle x5 = 0x22222222.
- Alloc x7 → o_busy_count 1, busy on x7; write x7 = 0xCAFEBABE → next cycle busy 0, count 0, data 0xCAFEBABE.
- BYPASS_EN=1: write x10 = 0xDEADBEEF with x10 busy, reading x10 same cycle → rdata 0xDEADBEEF, busy 0; BYPASS_EN=0 instance shows old data, busy 1.
- Same cycle alloc x3 + write x3 = 0x55555555 → next cycle data 0x55555555, busy 1; write/alloc to x0 → x0 reads 0, count unchanged.
- Alloc x1..x31, then assert reset one cycle → o_busy_count 31 before, 0 after, all data 0.
